tracker_enemy: RTL

Parametrised player-tracking enemy for the invader set. It chases the player in X, and optionally in Y. It fires from a pool of N_SHOTS independent projectiles and detects hits from the player projectile. After a hit it scores and respawns at a randomised X after a timed explosion. It sits beside the other enemy blocks under the game top level, driven by the game clock and the `play` flag.

---
 rtl/tracker_enemy_if.sv | 32 +++
 rtl/tracker_enemy.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tracker_enemy_if.sv
// Bundles the play/stimulus inputs and the enemy/shot outputs of tracker_enemy.
// The slave modport is the enemy side. The master modport is the game-top or bench side.
interface tracker_enemy_if #(
    parameter int N_SHOTS = 3
);
    logic                   i_play;
    logic [4:0]             i_rand;
    logic [9:0]             i_projectiles_x;
    logic [9:0]             i_projectiles_y;
    logic [9:0]             i_player_x;
    logic [9:0]             i_player_y;
    logic [10*N_SHOTS-1:0]  o_shots_x;
    logic [10*N_SHOTS-1:0]  o_shots_y;
    logic [N_SHOTS-1:0]     o_shots_active;
    logic [9:0]             o_enemy_x;
    logic [9:0]             o_enemy_y;
    logic                   o_alive;
    logic                   o_collision;
    logic [13:0]            o_score;

    modport slave (
        input  i_play, i_rand, i_projectiles_x, i_projectiles_y, i_player_x, i_player_y,
        output o_shots_x, o_shots_y, o_shots_active, o_enemy_x, o_enemy_y,
               o_alive, o_collision, o_score
    );

    modport master (
        output i_play, i_rand, i_projectiles_x, i_projectiles_y, i_player_x, i_player_y,
        input  o_shots_x, o_shots_y, o_shots_active, o_enemy_x, o_enemy_y,
               o_alive, o_collision, o_score
    );
endinterface

// File: rtl/tracker_enemy.sv
// Player-tracking enemy: it chases the player, fires from a shot pool, scores hits and respawns.
// Define ENEMY_Y_TRACK_EN to also track player_y, clamped to [SPAWN_Y, Y_LIMIT].
module tracker_enemy #(
    parameter int N_SHOTS     = 3,
    parameter int MOVE_DIV    = 2,
    parameter int FIRE_PERIOD = 512,
    parameter int SHOT_SPEED  = 2,
    parameter int HIT_W       = 10,
    parameter int HIT_H       = 20,
    parameter int SCORE_INC   = 50,
    parameter int SPAWN_X     = 64,
    parameter int SPAWN_Y     = 30,
    parameter int Y_LIMIT     = 240,
    parameter int RESPAWN_CYC = 256
) (
    input  logic           clk,
    input  logic           clr,
    tracker_enemy_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_HIT    = 2'd2;

    localparam int RW = $clog2(RESPAWN_CYC + 1);
    localparam logic signed [10:0] HIT_H_S   = 11'(HIT_H);
    localparam logic [10:0]        HIT_W_U   = 11'(HIT_W);
    localparam logic [9:0]         Y_BASE    = 10'(SPAWN_Y);
    localparam logic [9:0]         Y_LIM     = 10'(Y_LIMIT);
    localparam logic [14:0]        SCORE_MAX = 15'h3FFF;

    logic [1:0]          r_state;
    logic [MOVE_DIV-1:0] r_move_cnt;
    logic [15:0]         r_fire_cnt;
    logic [RW-1:0]       r_hit_cnt;
    logic [9:0]          r_enemy_x;
    logic [9:0]          r_enemy_y;
    logic [13:0]         r_score;
    logic                r_collision;
    logic [9:0]          r_shot_x [N_SHOTS];
    logic [9:0]          r_shot_y [N_SHOTS];
    logic [N_SHOTS-1:0]  r_shot_act;

    logic                w_tick;
    logic signed [10:0]  w_dx;
    logic signed [10:0]  w_dy;
    logic [10:0]         w_adx;
    logic                w_hit;
    logic                w_fire_wrap;
    logic                w_fire;
    logic                w_found;
    logic [N_SHOTS-1:0]  w_load;
    logic [14:0]         w_score_sum;
    logic [9:0]          w_y_target;

    assign w_tick = &r_move_cnt;

    // Difference in 11-bit signed arithmetic so that negative offsets stay negative.
    assign w_dx  = $signed({1'b0, bus.i_projectiles_x}) - $signed({1'b0, r_enemy_x});
    assign w_dy  = $signed({1'b0, bus.i_projectiles_y}) - $signed({1'b0, r_enemy_y});
    assign w_adx = w_dx[10] ? $unsigned(-w_dx) : $unsigned(w_dx);
    assign w_hit = (r_state == S_ACTIVE) && (bus.i_projectiles_y != 10'd0)
                && (w_dy > 11'sd0) && (w_dy < HIT_H_S) && (w_adx < HIT_W_U);

    assign w_fire_wrap = (r_state == S_ACTIVE) && (r_fire_cnt == 16'(FIRE_PERIOD - 1));
    assign w_fire      = w_fire_wrap && !w_hit;
    assign w_score_sum = {1'b0, r_score} + 15'(SCORE_INC);

`ifdef ENEMY_Y_TRACK_EN
    assign w_y_target = bus.i_player_y;
`else
    logic w_unused_player_y;
    assign w_y_target        = Y_BASE;
    assign w_unused_player_y = ^bus.i_player_y;
`endif

    always_comb begin
        w_load  = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < N_SHOTS; i++) begin
            if (w_fire && !w_found && !r_shot_act[i]) begin
                w_load[i] = 1'b1;
                w_found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= S_IDLE;
            r_move_cnt  <= '0;
            r_fire_cnt  <= '0;
            r_hit_cnt   <= '0;
            r_enemy_x   <= 10'(SPAWN_X);
            r_enemy_y   <= Y_BASE;
            r_score     <= '0;
            r_collision <= 1'b0;
        end else if (!bus.i_play) begin
            r_state     <= S_IDLE;
            r_move_cnt  <= '0;
            r_fire_cnt  <= '0;
            r_hit_cnt   <= '0;
            r_enemy_x   <= 10'(SPAWN_X);
            r_enemy_y   <= Y_BASE;
            r_score     <= '0;
            r_collision <= 1'b0;
        end else begin
            r_move_cnt  <= r_move_cnt + 1'b1;
            r_collision <= 1'b0;
            case (r_state)
                S_IDLE: r_state <= S_ACTIVE;
                S_ACTIVE: begin
                    r_fire_cnt <= w_fire_wrap ? '0 : r_fire_cnt + 16'd1;
                    if (w_hit) begin
                        r_state     <= S_HIT;
                        r_hit_cnt   <= '0;
                        r_collision <= 1'b1;
                        r_score     <= (w_score_sum > SCORE_MAX) ? 14'h3FFF : w_score_sum[13:0];
                    end else if (w_tick) begin
                        if (bus.i_player_x > r_enemy_x)
                            r_enemy_x <= r_enemy_x + 10'd1;
                        else if (bus.i_player_x < r_enemy_x)
                            r_enemy_x <= r_enemy_x - 10'd1;
                        if (w_y_target > r_enemy_y && r_enemy_y < Y_LIM)
                            r_enemy_y <= r_enemy_y + 10'd1;
                        else if (w_y_target < r_enemy_y && r_enemy_y > Y_BASE)
                            r_enemy_y <= r_enemy_y - 10'd1;
                    end
                end
                S_HIT: begin
                    if (r_hit_cnt == RW'(RESPAWN_CYC - 1)) begin
                        r_state   <= S_ACTIVE;
                        r_enemy_x <= 10'(SPAWN_X) + {1'b0, bus.i_rand, 4'b0000};
                        r_enemy_y <= Y_BASE;
                    end else begin
                        r_hit_cnt <= r_hit_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A fresh load takes priority over advancing or retiring the same slot.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int unsigned i = 0; i < N_SHOTS; i++) begin
                r_shot_x[i] <= '0;
                r_shot_y[i] <= '0;
            end
            r_shot_act <= '0;
        end else if (!bus.i_play) begin
            for (int unsigned i = 0; i < N_SHOTS; i++) begin
                r_shot_x[i] <= '0;
                r_shot_y[i] <= '0;
            end
            r_shot_act <= '0;
        end else begin
            for (int unsigned i = 0; i < N_SHOTS; i++) begin
                if (w_load[i]) begin
                    r_shot_x[i]   <= r_enemy_x;
                    r_shot_y[i]   <= r_enemy_y + 10'(HIT_H);
                    r_shot_act[i] <= 1'b1;
                end else if (w_tick && r_shot_act[i]) begin
                    if (({1'b0, r_shot_y[i]} + 11'(SHOT_SPEED)) > 11'd479) begin
                        r_shot_y[i]   <= '0;
                        r_shot_act[i] <= 1'b0;
                    end else begin
                        r_shot_y[i] <= r_shot_y[i] + 10'(SHOT_SPEED);
                    end
                end
            end
        end
    end

    always_comb begin
        bus.o_shots_x = '0;
        bus.o_shots_y = '0;
        for (int unsigned i = 0; i < N_SHOTS; i++) begin
            bus.o_shots_x[10*i +: 10] = r_shot_x[i];
            bus.o_shots_y[10*i +: 10] = r_shot_y[i];
        end
    end

    assign bus.o_shots_active = r_shot_act;
    assign bus.o_enemy_x      = r_enemy_x;
    assign bus.o_enemy_y      = r_enemy_y;
    assign bus.o_alive        = (r_state == S_ACTIVE);
    assign bus.o_collision    = r_collision;
    assign bus.o_score        = r_score;
endmodule
